// File: rtl/int2float_rr_sched_if.sv
// Request/result/conversion-unit bundle for the int2float scheduler.
// Latency: none, wires only.
// Backpressure: req_ready and res_ready carry the stalls in each direction.
interface int2float_rr_sched_if #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*11-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic [10:0]        cv_x;
    logic [6:0]         cv_y;
    logic               res_valid;
    logic               res_ready;
    logic [6:0]         res_data;
    logic [IDW-1:0]     res_src;

    // Scheduler side
    modport master (
        input  req_valid, req_data, cv_y, res_ready,
        output req_ready, cv_x, res_valid, res_data, res_src
    );

    // Producer / consumer / conversion-netlist side
    modport slave (
        output req_valid, req_data, cv_y, res_ready,
        input  req_ready, cv_x, res_valid, res_data, res_src
    );
endinterface

// File: rtl/int2float_rr_sched.sv
// Round-robin scheduler feeding one shared int2float netlist, results tagged by source.
// Latency: accept at edge k -> res_valid after edge k+1; 1 result/cycle when unstalled.
// Backpressure: 2-stage stallable pipe; req_ready drops once both stages are held.
module int2float_rr_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ),
    parameter int CNTW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    int2float_rr_sched_if.master bus,
    output logic                 busy,
    output logic [CNTW-1:0]      done_count
);
    // S1: operand presented to the conversion netlist
    logic            s1_valid;
    logic [10:0]     s1_x;
    logic [IDW-1:0]  s1_src;
    // S2: registered result towards the consumer
    logic            res_valid_q;
    logic [6:0]      res_data_q;
    logic [IDW-1:0]  res_src_q;

    logic [IDW-1:0]  rr_ptr;
    logic [CNTW-1:0] done_q;

    logic            s2_free, s1_adv, s1_free;
    logic [NREQ-1:0] grant;
    logic            accept;
    logic [IDW-1:0]  gidx;
    logic [10:0]     gdata;
    int              best_j, best_d;

    assign s2_free = !res_valid_q || bus.res_ready;
    assign s1_adv  = s1_valid && s2_free;
    assign s1_free = !s1_valid || s1_adv;

    // Pick the valid requester closest after rr_ptr; grant only when S1 can take it.
    always_comb begin
        best_j = NREQ;
        best_d = NREQ;
        grant  = '0;
        gdata  = '0;
        for (int j = 0; j < NREQ; j++) begin
            int d;
            d = (j + 2 * NREQ - 1 - int'(rr_ptr)) % NREQ;
            if (bus.req_valid[j] && d < best_d) begin
                best_d = d;
                best_j = j;
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            grant[j] = s1_free && !rst && (j == best_j);
            if (j == best_j) begin
                gdata = bus.req_data[j*11 +: 11];
            end
        end
        gidx = IDW'(best_j);
    end

    assign accept        = |grant;
    assign bus.req_ready = grant;
    assign bus.cv_x      = s1_x;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_src   = res_src_q;
    assign busy          = s1_valid || res_valid_q;
    assign done_count    = done_q;

    // Pipeline advance, arbitration pointer and delivery counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_x        <= '0;
            s1_src      <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_src_q   <= '0;
            rr_ptr      <= IDW'(NREQ - 1);
            done_q      <= '0;
        end else begin
            if (accept) begin
                s1_x     <= gdata;
                s1_src   <= gidx;
                s1_valid <= 1'b1;
                rr_ptr   <= gidx;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end

            if (s1_adv) begin
                res_data_q  <= bus.cv_y;
                res_src_q   <= s1_src;
                res_valid_q <= 1'b1;
            end else if (res_valid_q && bus.res_ready) begin
                res_valid_q <= 1'b0;
            end

            if (res_valid_q && bus.res_ready) begin
                done_q <= done_q + CNTW'(1);
            end
        end
    end
endmodule

// File: tb/tb_int2float_rr_sched.sv
module tb_int2float_rr_sched;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int CNTW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            busy;
    logic [CNTW-1:0] done_count;

    int n_chk  = 0;
    int n_fail = 0;

    int2float_rr_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    // Stand-in for the external conversion netlist: {exp(4), mant(3)}
    function automatic logic [6:0] conv(input logic [10:0] x);
        int p;
        logic [10:0] m;
        p = -1;
        for (int i = 0; i < 11; i++) if (x[i]) p = i;
        if (p < 0) return 7'd0;
        if (p >= 3) m = x >> (p - 3);
        else        m = x << (3 - p);
        return {4'(p + 1), m[2:0]};
    endfunction

    assign bus.cv_y = conv(bus.cv_x);

    int2float_rr_sched #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.master),
        .busy       (busy),
        .done_count (done_count)
    );

    always #5 clk = ~clk;

    // Reference model: ordered queue of in-flight operands, capacity two.
    int          mq_src[$];
    logic [10:0] mq_dat[$];
    bit          m_fresh = 1'b0;
    int          m_ptr   = NREQ - 1;
    int          m_cnt   = 0;

    function automatic int exp_grant();
        if (rst) return -1;
        if (!(mq_src.size() < 2 || bus.res_ready)) return -1;
        for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (m_ptr + k) % NREQ;
            if (bus.req_valid[j]) return j;
        end
        return -1;
    endfunction

    function automatic bit exp_res_valid();
        return mq_src.size() > 0 && !(mq_src.size() == 1 && m_fresh);
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int g);
        logic [NREQ-1:0] v;
        v = '0;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    // One clock edge: advance the model from the inputs seen before it, end at negedge.
    task automatic cycle();
        int g;
        bit pop, rf;
        logic [10:0] gd;
        g  = exp_grant();
        gd = (g >= 0) ? bus.req_data[g*11 +: 11] : 11'd0;
        pop = exp_res_valid() && bus.res_ready;
        rf  = rst;
        @(posedge clk);
        if (rf) begin
            mq_src.delete();
            mq_dat.delete();
            m_fresh = 1'b0;
            m_ptr   = NREQ - 1;
            m_cnt   = 0;
        end else begin
            if (pop) begin
                void'(mq_src.pop_front());
                void'(mq_dat.pop_front());
                m_cnt = (m_cnt + 1) % (1 << CNTW);
            end
            m_fresh = 1'b0;
            if (g >= 0) begin
                mq_src.push_back(g);
                mq_dat.push_back(gd);
                m_ptr   = g;
                m_fresh = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        bus.req_valid = '0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.req_valid = '1;
        bus.req_data  = {$urandom, $urandom};
        bus.res_ready = 1'b1;
        rst = 1'b1;
        cycle();
        #1;
        n_chk++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_ready got=%b exp=0000", bus.req_ready); end
        n_chk++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_res_valid got=%b exp=0", bus.res_valid); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
        n_chk++; if (done_count !== 4'd0) begin n_fail++; $display("FAIL rst_done got=%0d exp=0", done_count); end
        n_chk++; if (bus.res_src !== 2'd0) begin n_fail++; $display("FAIL rst_src got=%0d exp=0", bus.res_src); end
        n_chk++; if (bus.cv_x !== 11'd0) begin n_fail++; $display("FAIL rst_cvx got=%0d exp=0", bus.cv_x); end
        cycle();
        #1;
        n_chk++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_ready2 got=%b exp=0000", bus.req_ready); end
        rst = 1'b0;
        #1;
        n_chk++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL first_grant got=%b exp=0001", bus.req_ready); end
        bus.req_valid = '0;
        cycle();
        cycle();
        cycle();
    endtask

    task automatic test_single_op();
        logic [6:0] ey;
        reset_pulse();
        ey = conv(11'd1000);
        bus.req_data = '0;
        bus.req_data[2*11 +: 11] = 11'd1000;
        bus.req_valid = 4'b0100;
        bus.res_ready = 1'b1;
        #1;
        n_chk++; if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_grant got=%b exp=0100", bus.req_ready); end
        cycle();
        bus.req_valid = '0;
        #1;
        n_chk++; if (bus.cv_x !== 11'd1000) begin n_fail++; $display("FAIL single_cvx got=%0d exp=1000", bus.cv_x); end
        n_chk++; if (bus.res_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL single_s1 got valid=%b busy=%b exp 0/1", bus.res_valid, busy); end
        cycle();
        #1;
        n_chk++; if (bus.res_valid !== 1'b1 || bus.res_src !== 2'd2) begin n_fail++; $display("FAIL single_res got valid=%b src=%0d exp 1/2", bus.res_valid, bus.res_src); end
        n_chk++; if (bus.res_data !== ey) begin n_fail++; $display("FAIL single_data got=%h exp=%h", bus.res_data, ey); end
        cycle();
        #1;
        n_chk++; if (done_count !== 4'd1 || busy !== 1'b0) begin n_fail++; $display("FAIL single_done got cnt=%0d busy=%b exp 1/0", done_count, busy); end
    endtask

    task automatic test_fairness();
        logic [10:0] d [NREQ];
        reset_pulse();
        for (int i = 0; i < NREQ; i++) begin
            d[i] = 11'($urandom);
            bus.req_data[i*11 +: 11] = d[i];
        end
        bus.res_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            bus.req_valid = (c < 8) ? 4'b1111 : 4'b0000;
            #1;
            if (c < 8) begin
                n_chk++; if (bus.req_ready !== onehot(c % 4)) begin n_fail++; $display("FAIL fair_grant c=%0d got=%b exp=%b", c, bus.req_ready, onehot(c % 4)); end
            end
            if (c >= 2) begin
                n_chk++;
                if (bus.res_valid !== 1'b1 || bus.res_src !== 2'((c - 2) % 4) || bus.res_data !== conv(d[(c - 2) % 4])) begin
                    n_fail++; $display("FAIL fair_res c=%0d got v=%b src=%0d dat=%h exp src=%0d", c, bus.res_valid, bus.res_src, bus.res_data, (c - 2) % 4);
                end
            end
            cycle();
        end
        #1;
        n_chk++; if (done_count !== 4'd8) begin n_fail++; $display("FAIL fair_done got=%0d exp=8", done_count); end
    endtask

    task automatic test_backpressure();
        int acc;
        int accq[$];
        int got[$];
        logic [6:0] fd;
        logic [IDW-1:0] fs;
        bit frozen;
        reset_pulse();
        bus.req_data  = {$urandom, $urandom};
        bus.res_ready = 1'b0;
        bus.req_valid = 4'b1111;
        acc = 0;
        frozen = 1'b0;
        fd = '0;
        fs = '0;
        for (int c = 0; c < 5; c++) begin
            #1;
            for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) begin acc++; accq.push_back(i); end
            if (frozen) begin
                n_chk++; if (bus.res_data !== fd || bus.res_src !== fs || bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL bp_frozen c=%0d got src=%0d dat=%h exp src=%0d dat=%h", c, bus.res_src, bus.res_data, fs, fd); end
            end else if (bus.res_valid === 1'b1) begin
                frozen = 1'b1; fd = bus.res_data; fs = bus.res_src;
            end
            cycle();
        end
        n_chk++; if (acc != 2) begin n_fail++; $display("FAIL bp_accepts got=%0d exp=2", acc); end
        bus.req_valid = '0;
        bus.res_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (bus.res_valid === 1'b1) got.push_back(int'(bus.res_src));
            if (c < 2) begin
                n_chk++; if (bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL bp_gap c=%0d got valid=%b exp=1", c, bus.res_valid); end
            end
            cycle();
        end
        n_chk++; if (got != accq) begin n_fail++; $display("FAIL bp_order got=%p exp=%p", got, accq); end
        n_chk++; if (done_count !== 4'd2) begin n_fail++; $display("FAIL bp_done got=%0d exp=2", done_count); end
    endtask

    task automatic test_mid_reset();
        reset_pulse();
        bus.req_data  = {$urandom, $urandom};
        bus.req_valid = 4'b1111;
        bus.res_ready = 1'b1;
        for (int c = 0; c < 4; c++) cycle();
        bus.res_ready = 1'b0;
        for (int c = 0; c < 3; c++) cycle();
        #1;
        n_chk++; if (busy !== 1'b1 || bus.res_valid !== 1'b1 || done_count === 4'd0) begin n_fail++; $display("FAIL mr_pre got busy=%b valid=%b cnt=%0d exp 1/1/nonzero", busy, bus.res_valid, done_count); end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        bus.req_valid = '0;
        bus.res_ready = 1'b1;
        #1;
        n_chk++; if (bus.res_valid !== 1'b0 || busy !== 1'b0 || done_count !== 4'd0) begin n_fail++; $display("FAIL mr_post got valid=%b busy=%b cnt=%0d exp 0/0/0", bus.res_valid, busy, done_count); end
        for (int c = 0; c < 4; c++) begin
            cycle();
            #1;
            n_chk++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL mr_ghost c=%0d got valid=%b exp=0", c, bus.res_valid); end
        end
    endtask

    task automatic test_wrap();
        int del;
        bit hs;
        reset_pulse();
        bus.req_data  = {$urandom, $urandom};
        bus.req_valid = 4'b1111;
        bus.res_ready = 1'b1;
        del = 0;
        for (int c = 0; c < 40 && del < 17; c++) begin
            #1;
            hs = bus.res_valid;
            cycle();
            if (hs) begin
                del++;
                if (del == 15 || del == 16 || del == 17) begin
                    n_chk++;
                    if (done_count !== 4'(del % 16)) begin n_fail++; $display("FAIL wrap_%0d got=%0d exp=%0d", del, done_count, del % 16); end
                end
            end
        end
        n_chk++; if (del < 17) begin n_fail++; $display("FAIL wrap_timeout got=%0d exp=17 deliveries", del); end
        bus.req_valid = '0;
    endtask

    task automatic test_random();
        reset_pulse();
        for (int c = 0; c < 400; c++) begin
            bus.req_valid = 4'($urandom);
            bus.req_data  = {$urandom, $urandom};
            bus.res_ready = ($urandom_range(0, 9) < 7);
            rst = ($urandom_range(0, 63) == 0);
            #1;
            n_chk++; if (bus.req_ready !== onehot(exp_grant())) begin n_fail++; $display("FAIL rnd_grant c=%0d got=%b exp=%b", c, bus.req_ready, onehot(exp_grant())); end
            n_chk++; if (bus.res_valid !== exp_res_valid()) begin n_fail++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, bus.res_valid, exp_res_valid()); end
            if (exp_res_valid()) begin
                n_chk++;
                if (bus.res_src !== 2'(mq_src[0]) || bus.res_data !== conv(mq_dat[0])) begin
                    n_fail++; $display("FAIL rnd_res c=%0d got src=%0d dat=%h exp src=%0d dat=%h", c, bus.res_src, bus.res_data, mq_src[0], conv(mq_dat[0]));
                end
            end
            if (mq_src.size() == 2 || (mq_src.size() == 1 && m_fresh)) begin
                n_chk++; if (bus.cv_x !== mq_dat[mq_dat.size() - 1]) begin n_fail++; $display("FAIL rnd_cvx c=%0d got=%0d exp=%0d", c, bus.cv_x, mq_dat[mq_dat.size() - 1]); end
            end
            n_chk++; if (busy !== (mq_src.size() > 0)) begin n_fail++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, busy, mq_src.size() > 0); end
            n_chk++; if (done_count !== 4'(m_cnt)) begin n_fail++; $display("FAIL rnd_done c=%0d got=%0d exp=%0d", c, done_count, m_cnt); end
            cycle();
        end
        rst = 1'b0;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.res_ready = 1'b0;
        test_reset();
        test_single_op();
        test_fairness();
        test_backpressure();
        test_mid_reset();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
